mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk_in  in  1  system clock; all state updates on rising edge.
REQ-002 rst_in  in  1  reset; asynchronous, active-high.
REQ-003 rdy_in  in  1  global ready; low freezes the block.
REQ-004 if_req  in  1  instruction-fetch request (4-byte read).
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_abort  in  1  branch flush; cancels a pending or in-flight fetch.
REQ-007 if_data  out  32  fetched word, little-endian.
REQ-008 if_done  out  1  one-cycle pulse: if_data valid.
REQ-009 mem_req  in  1  MEM-stage load/store request.
REQ-010 mem_we  in  1  1 = store, 0 = load.
REQ-011 mem_addr  in  32  load/store byte address.
REQ-012 mem_len  in  3  byte count; only 1, 2 or 4 are legal.
REQ-013 mem_wdata  in  32  store data; low mem_len bytes are used.
REQ-014 mem_rdata  out  32  load data, zero-extended.
REQ-015 mem_done  out  1  one-cycle pulse: access complete.
REQ-016 stall_req_if  out  1  combinational: if_req && !if_done.
REQ-017 stall_req_mem  out  1  combinational: mem_req && !mem_done.
REQ-018 ram_din  in  8  RAM read byte; valid one cycle after its address.
REQ-019 ram_dout  out  8  RAM write byte.
REQ-020 ram_a  out  32  RAM byte address.
REQ-021 ram_wr  out  1  1 = write cycle.
REQ-022 io_buffer_full  in  1  UART buffer full.

Function
REQ-023 The block SHALL implement the states IDLE, IF_READ, MEM_READ and MEM_WRITE, with a byte counter cnt[2:0] and latched base, len and wdata.
REQ-024 A request SHALL be accepted only in IDLE; when both requests are pending, MEM SHALL win; accepting a request latches its address, length and data.
REQ-025 In IDLE, a requester whose done pulse is high in that cycle SHALL be ignored, which prevents double acceptance.
REQ-026 An in-progress access SHALL never be preempted; a mem_req raised during IF_READ SHALL be served at the next IDLE.
REQ-027 READ, cycle k = 0..len:
  - for k < len, drive ram_a = base + k with ram_wr = 0;
  - for k >= 1, capture ram_din into byte k-1.
  - After k = len, return to IDLE and pulse done.
  - Done SHALL appear len+2 cycles after the acceptance edge.
REQ-028 WRITE, cycle k = 0..len-1:
  - drive ram_a = base + k, ram_wr = 1, ram_dout = wdata[8k+7:8k].
  - After the last byte, return to IDLE and pulse mem_done.
  - mem_done SHALL appear len+1 cycles after acceptance.
REQ-029 WRITE to an I/O address (base[17:16] == 2'b11) while io_buffer_full = 1:
  - ram_wr = 0, cnt SHALL hold, the byte is retried;
  - done is delayed by one cycle per blocked cycle.
REQ-030 Load results SHALL be zero-extended: a 1-byte load yields {24'b0, byte0} and a 2-byte load yields {16'b0, byte1, byte0}.
REQ-031 if_data and mem_rdata SHALL hold their value until the next respective done pulse.
REQ-032 if_abort SHALL behave as follows:
  - high in IF_READ: return to IDLE next cycle with no if_done;
  - high in IDLE: a pending if_req SHALL not be accepted that cycle;
  - if_abort SHALL have no effect on MEM states.
REQ-033 rdy_in = 0 SHALL hold all state, outputs and cnt, force ram_wr = 0, keep ram_a stable, and suppress capture; operation resumes exactly where it stopped.
REQ-034 In IDLE, the block SHALL drive ram_wr = 0 and ram_a = 0.
REQ-035 An illegal mem_len (0, 3, 5–7) SHALL be treated as 4.

Reset
REQ-036 When rst_in is asserted, the block SHALL immediately enter IDLE and clear cnt, if_data, mem_rdata, ram_a and ram_dout to 0, and drive if_done, mem_done and ram_wr to 0.
REQ-037 Reset mid-access SHALL abort the access with no done pulse and no further RAM writes.

Verification
REQ-038 Fetch: RAM[0x100..0x103] = 13 00 00 00, if_req @0x100 -> ram_a walks 0x100..0x103; if_done after 6 cycles with if_data = 0x00000013.
REQ-039 Simultaneous if_req @0x0 and mem_req load len=2 @0x200 with RAM = 34 12:
  - mem_done first, mem_rdata = 0x00001234;
  - the fetch then starts the cycle after mem_done.
REQ-040 Store: len=4, mem_wdata = 0xAABBCCDD @0x10 -> ram_wr = 1 with (0x10,DD), (0x11,CC), (0x12,BB), (0x13,AA); mem_done after 5 cycles.
REQ-041 Store: len=1 @0x30000 with io_buffer_full high for 3 cycles -> ram_wr stays 0 for those 3 cycles, then one write, then mem_done.
REQ-042 Fetch interrupted twice:
  - if_abort at read cycle k=2 -> IDLE, no if_done;
  - rdy_in low for 2 cycles mid-read -> same if_data as an unstalled run, with done delayed by 2 cycles.
REQ-043 rst_in pulsed during a store at cycle k=1 -> no further ram_wr, no mem_done, block in IDLE; a new request afterwards completes normally.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bundles the fetch port, load/store port and byte-wide RAM bus of mem_ctrl.
// The slave modport is the controller's view; master is the CPU/RAM side.
interface mem_ctrl_if;
    logic        rdy_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_abort;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_len;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stall_req_if;
    logic        stall_req_mem;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full;

    modport slave (
        input  rdy_in, if_req, if_addr, if_abort,
        input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        input  ram_din, io_buffer_full,
        output if_data, if_done, mem_rdata, mem_done,
        output stall_req_if, stall_req_mem,
        output ram_dout, ram_a, ram_wr
    );

    modport master (
        output rdy_in, if_req, if_addr, if_abort,
        output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
        output ram_din, io_buffer_full,
        input  if_data, if_done, mem_rdata, mem_done,
        input  stall_req_if, stall_req_mem,
        input  ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store
// accesses onto a single byte-wide synchronous RAM port.
module mem_ctrl (
    input  logic         clk_in,
    input  logic         rst_in,
    mem_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, IF_READ, MEM_READ, MEM_WRITE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic        rdy_prev_q;
    logic [7:0]  din_hold_q;

    logic        is_read;
    logic        io_blocked;
    logic        issuing;
    logic        cap_en;
    logic [2:0]  cap_idx;
    logic [7:0]  byte_in;
    logic [31:0] merged;
    logic [2:0]  mem_len_eff;
    logic        mem_go;
    logic        if_go;
    logic [7:0]  wbyte;

    // The RAM keeps answering for the frozen address while rdy_in is low, so the
    // byte that belonged to the last active cycle is parked and replayed on resume.
    assign byte_in    = rdy_prev_q ? bus.ram_din : din_hold_q;

    assign is_read    = (state_q == IF_READ) || (state_q == MEM_READ);
    assign io_blocked = (base_q[17:16] == 2'b11) && bus.io_buffer_full;
    assign issuing    = (is_read && (cnt_q < len_q)) || (state_q == MEM_WRITE);
    assign cap_en     = is_read && bus.rdy_in && (cnt_q != 3'd0);
    assign cap_idx    = cnt_q - 3'd1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = (cap_en && (cap_idx == 3'(gi))) ? byte_in
                                                                        : rbuf_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        case (bus.mem_len)
            3'd1:    mem_len_eff = 3'd1;
            3'd2:    mem_len_eff = 3'd2;
            default: mem_len_eff = 3'd4;
        endcase
    end

    always_comb begin
        case (cnt_q[1:0])
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase
    end

    // A requester whose done pulse is still visible is ignored to avoid re-acceptance.
    assign mem_go = bus.mem_req && !mem_done_q;
    assign if_go  = bus.if_req && !if_done_q && !bus.if_abort;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        if (bus.rdy_in) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
            rbuf_d     = merged;
            case (state_q)
                IDLE: begin
                    if (mem_go) begin
                        state_d = bus.mem_we ? MEM_WRITE : MEM_READ;
                        cnt_d   = 3'd0;
                        base_d  = bus.mem_addr;
                        len_d   = mem_len_eff;
                        wdata_d = bus.mem_wdata;
                        rbuf_d  = 32'd0;
                    end else if (if_go) begin
                        state_d = IF_READ;
                        cnt_d   = 3'd0;
                        base_d  = bus.if_addr;
                        len_d   = 3'd4;
                        rbuf_d  = 32'd0;
                    end
                end
                IF_READ, MEM_READ: begin
                    if ((state_q == IF_READ) && bus.if_abort) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else if (cnt_q == len_q) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                        if (state_q == IF_READ) begin
                            if_data_d = merged;
                            if_done_d = 1'b1;
                        end else begin
                            mem_rdata_d = merged;
                            mem_done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                MEM_WRITE: begin
                    if (!io_blocked) begin
                        if (cnt_q == len_q - 3'd1) begin
                            state_d    = IDLE;
                            cnt_d      = 3'd0;
                            mem_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rbuf_q      <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            rdy_prev_q  <= 1'b0;
            din_hold_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            rdy_prev_q  <= bus.rdy_in;
            din_hold_q  <= byte_in;
        end
    end

    assign bus.ram_a         = issuing ? (base_q + {29'd0, cnt_q}) : 32'd0;
    assign bus.ram_wr        = (state_q == MEM_WRITE) && bus.rdy_in && !io_blocked;
    assign bus.ram_dout      = (state_q == MEM_WRITE) ? wbyte : 8'd0;
    assign bus.if_data       = if_data_q;
    assign bus.if_done       = if_done_q;
    assign bus.mem_rdata     = mem_rdata_q;
    assign bus.mem_done      = mem_done_q;
    assign bus.stall_req_if  = bus.if_req && !if_done_q;
    assign bus.stall_req_mem = bus.mem_req && !mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: drivers push expected responses, monitors pop
// and compare on every done pulse and every RAM write cycle.
module tb_mem_ctrl;

    logic clk_in = 1'b0;
    logic rst_in;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          is_load;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    resp_t exp_if[$];
    resp_t exp_mem[$];
    wr_t   exp_wr[$];

    logic [7:0]  ram_mem   [0:262143];
    logic [7:0]  model_mem [0:262143];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          hold_viol = 0;
    logic [31:0] if_last = 32'd0;
    logic [31:0] mem_last = 32'd0;

    // Synchronous-read byte RAM attached to the controller.
    always @(posedge clk_in) begin
        if (bus.ram_wr) ram_mem[bus.ram_a[17:0]] <= bus.ram_dout;
        bus.ram_din <= ram_mem[bus.ram_a[17:0]];
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int eff_len(input logic [2:0] l);
        return (l == 3'd1 || l == 3'd2) ? int'(l) : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        logic [17:0] ix;
        r = 32'd0;
        for (int i = 0; i < n; i++) begin
            ix = 18'(a + 32'(i));
            r[8*i +: 8] = model_mem[ix];
        end
        return r;
    endfunction

    // Read latency: done sampled len+2 edges after acceptance; write: len+1.
    task automatic issue_fetch(input logic [31:0] a, input int extra);
        resp_t e;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        e.data = model_read(a, 4);
        e.cyc = cyc + 6 + extra;
        e.is_load = 1'b1;
        exp_if.push_back(e);
    endtask

    task automatic issue_mem(input bit we, input logic [31:0] a, input logic [2:0] l,
                             input logic [31:0] w, input int extra);
        int n;
        resp_t e;
        wr_t wr;
        logic [17:0] ix;
        n = eff_len(l);
        bus.mem_req   = 1'b1;
        bus.mem_we    = we;
        bus.mem_addr  = a;
        bus.mem_len   = l;
        bus.mem_wdata = w;
        if (we) begin
            for (int k = 0; k < n; k++) begin
                wr.addr = a + 32'(k);
                wr.data = w[8*k +: 8];
                exp_wr.push_back(wr);
                ix = 18'(a + 32'(k));
                model_mem[ix] = w[8*k +: 8];
            end
            e.data = 32'd0;
            e.cyc = cyc + n + 1 + extra;
            e.is_load = 1'b0;
        end else begin
            e.data = model_read(a, n);
            e.cyc = cyc + n + 2 + extra;
            e.is_load = 1'b1;
        end
        exp_mem.push_back(e);
    endtask

    task automatic wait_done(input bit is_if);
        int n;
        logic d;
        string s;
        s = is_if ? "if" : "mem";
        n = 0;
        d = 1'b0;
        do begin
            @(negedge clk_in);
            n++;
            d = is_if ? bus.if_done : bus.mem_done;
            if (n == 1 && !d)
                chk({s, "_stall_busy"}, {31'd0, is_if ? bus.stall_req_if : bus.stall_req_mem}, 32'd1);
        end while (!d && n < 80);
        if (!d) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done, expected done within 80 cycles", s);
        end else begin
            chk({s, "_stall_at_done"}, {31'd0, is_if ? bus.stall_req_if : bus.stall_req_mem}, 32'd0);
        end
        @(posedge clk_in);
        #1;
    endtask

    // Monitor: compares every done pulse and RAM write against the scoreboard.
    always @(negedge clk_in) begin
        resp_t e;
        wr_t w;
        if (rst_in) begin
            if_last  = bus.if_data;
            mem_last = bus.mem_rdata;
        end else begin
            if (bus.if_done) begin
                if (exp_if.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL if_done_unexpected: got if_done=1 expected 0 at cyc %0d", cyc);
                end else begin
                    e = exp_if.pop_front();
                    chk("if_data", bus.if_data, e.data);
                    chk("if_latency", 32'(cyc), 32'(e.cyc));
                    $display("fetch done: data=%h cyc=%0d", bus.if_data, cyc);
                end
            end else if (bus.if_data !== if_last) begin
                hold_viol++;
            end
            if (bus.mem_done) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_done_unexpected: got mem_done=1 expected 0 at cyc %0d", cyc);
                end else begin
                    e = exp_mem.pop_front();
                    if (e.is_load) chk("mem_rdata", bus.mem_rdata, e.data);
                    chk("mem_latency", 32'(cyc), 32'(e.cyc));
                    $display("%s done: rdata=%h cyc=%0d", e.is_load ? "load" : "store",
                             bus.mem_rdata, cyc);
                end
            end else if (bus.mem_rdata !== mem_last) begin
                hold_viol++;
            end
            if (bus.ram_wr) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ram_wr_unexpected: got write a=%h d=%h expected none",
                             bus.ram_a, bus.ram_dout);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", bus.ram_a, w.addr);
                    chk("wr_data", {24'd0, bus.ram_dout}, {24'd0, w.data});
                end
            end
            if_last  = bus.if_data;
            mem_last = bus.mem_rdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] w;
        logic [31:0] a;
        logic [2:0]  l;
        int          t;
        wr_t         wr;

        rst_in             = 1'b0;
        bus.rdy_in         = 1'b1;
        bus.if_req         = 1'b0;
        bus.if_addr        = 32'd0;
        bus.if_abort       = 1'b0;
        bus.mem_req        = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_addr       = 32'd0;
        bus.mem_len        = 3'd0;
        bus.mem_wdata      = 32'd0;
        bus.io_buffer_full = 1'b0;
        for (int i = 0; i < 262144; i++) begin
            b = 8'($urandom);
            ram_mem[i]   = b;
            model_mem[i] = b;
        end
        ram_mem[32'h100] = 8'h13; model_mem[32'h100] = 8'h13;
        ram_mem[32'h101] = 8'h00; model_mem[32'h101] = 8'h00;
        ram_mem[32'h102] = 8'h00; model_mem[32'h102] = 8'h00;
        ram_mem[32'h103] = 8'h00; model_mem[32'h103] = 8'h00;
        ram_mem[32'h200] = 8'h34; model_mem[32'h200] = 8'h34;
        ram_mem[32'h201] = 8'h12; model_mem[32'h201] = 8'h12;

        // Reset takes effect before any clock edge.
        #2 rst_in = 1'b1;
        #1;
        chk("rst_if_done", {31'd0, bus.if_done}, 32'd0);
        chk("rst_mem_done", {31'd0, bus.mem_done}, 32'd0);
        chk("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
        chk("rst_ram_a", bus.ram_a, 32'd0);
        chk("rst_ram_dout", {24'd0, bus.ram_dout}, 32'd0);
        chk("rst_if_data", bus.if_data, 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Fetch of 0x00000013 from 0x100, address walk observed.
        issue_fetch(32'h100, 0);
        @(posedge clk_in);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk("fetch_walk_a", bus.ram_a, 32'h100 + 32'(k));
        end
        wait_done(1'b1);
        bus.if_req = 1'b0;
        chk("fetch_0x13", bus.if_data, 32'h0000_0013);

        // Word store, little-endian byte order.
        issue_mem(1'b1, 32'h10, 3'd4, 32'hAABB_CCDD, 0);
        wait_done(1'b0);
        bus.mem_req = 1'b0;

        // Simultaneous requests: load wins, fetch starts right after.
        issue_mem(1'b0, 32'h200, 3'd2, $urandom, 0);
        issue_fetch(32'h0, 4);
        wait_done(1'b0);
        bus.mem_req = 1'b0;
        chk("arb_load_1234", bus.mem_rdata, 32'h0000_1234);
        wait_done(1'b1);
        bus.if_req = 1'b0;

        // I/O store blocked for three cycles by a full buffer.
        bus.io_buffer_full = 1'b1;
        issue_mem(1'b1, 32'h30000, 3'd1, $urandom, 3);
        @(posedge clk_in);
        repeat (3) begin
            @(negedge clk_in);
            chk("io_blocked_wr", {31'd0, bus.ram_wr}, 32'd0);
        end
        @(posedge clk_in);
        #1 bus.io_buffer_full = 1'b0;
        wait_done(1'b0);
        bus.mem_req = 1'b0;

        // Fetch aborted at k=2; abort in IDLE also blocks acceptance.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h180;
        repeat (3) @(posedge clk_in);
        #1 bus.if_abort = 1'b1;
        @(negedge clk_in);
        chk("abort_k2_a", bus.ram_a, 32'h182);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("abort_idle_a", bus.ram_a, 32'd0);
        @(posedge clk_in);
        #1;
        bus.if_req   = 1'b0;
        bus.if_abort = 1'b0;
        @(negedge clk_in);
        chk("abort_not_accepted_a", bus.ram_a, 32'd0);
        repeat (8) @(posedge clk_in);
        #1;

        // Fetch frozen for two cycles by rdy_in.
        issue_fetch(32'h300, 2);
        repeat (2) @(posedge clk_in);
        #1 bus.rdy_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("rdy_hold_a", bus.ram_a, 32'h301);
        @(posedge clk_in);
        #1 bus.rdy_in = 1'b1;
        wait_done(1'b1);
        bus.if_req = 1'b0;

        // Store frozen for one cycle: no write while rdy_in is low.
        issue_mem(1'b1, 32'h50, 3'd2, $urandom, 1);
        @(posedge clk_in);
        #1 bus.rdy_in = 1'b0;
        @(negedge clk_in);
        chk("rdy_low_no_wr", {31'd0, bus.ram_wr}, 32'd0);
        @(posedge clk_in);
        #1 bus.rdy_in = 1'b1;
        wait_done(1'b0);
        bus.mem_req = 1'b0;

        // Reset during store cycle k=1: only byte 0 lands, no done.
        w = $urandom;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h40;
        bus.mem_len   = 3'd4;
        bus.mem_wdata = w;
        wr.addr = 32'h40;
        wr.data = w[7:0];
        exp_wr.push_back(wr);
        model_mem[18'h40] = w[7:0];
        repeat (2) @(posedge clk_in);
        #1;
        rst_in      = 1'b1;
        bus.mem_req = 1'b0;
        @(negedge clk_in);
        chk("midrst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
        chk("midrst_ram_a", bus.ram_a, 32'd0);
        chk("midrst_mem_done", {31'd0, bus.mem_done}, 32'd0);
        chk("midrst_if_data", bus.if_data, 32'd0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        issue_mem(1'b0, 32'h40, 3'd4, 32'd0, 0);
        wait_done(1'b0);
        bus.mem_req = 1'b0;

        // Randomized mix of fetches, loads and stores (including illegal lengths).
        for (int i = 0; i < 40; i++) begin
            t = $urandom_range(0, 2);
            a = 32'($urandom_range(0, 4095));
            l = 3'($urandom_range(0, 7));
            w = $urandom;
            if (t == 0) begin
                issue_fetch(a, 0);
                wait_done(1'b1);
                bus.if_req = 1'b0;
            end else begin
                issue_mem(t == 2, a, l, w, 0);
                wait_done(1'b0);
                bus.mem_req = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk_in);
            #1;
        end

        repeat (5) @(posedge clk_in);
        #1;
        chk("if_queue_empty", 32'(exp_if.size()), 32'd0);
        chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("data_hold", 32'(hold_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
